// File: rtl/bcd2bin_if.sv
// bcd2bin_if: start/busy/done handshake and data bus for the BCD-to-binary converter
interface bcd2bin_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;
  modport master (output start, bcd_in, input busy, done, bin_out, err);
  modport slave  (input start, bcd_in, output busy, done, bin_out, err);
endinterface

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: iterative reverse double-dabble BCD-to-binary converter, one shift per clock
module bcd2bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic      clk,
  input  logic      rst_n,
  bcd2bin_if.slave  bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);
  typedef enum logic [1:0] {IDLE, CHECK, SHIFT, FINISH} state_t;
  state_t state, nxt;
  logic [BCD_W-1:0]       bcd_reg, bcd_adj;
  logic [BIN_W-1:0]       bin_reg;
  logic [CNT_W-1:0]       cnt;
  logic [BCD_W+BIN_W-1:0] shifted;
  logic                   bad;
  logic                   last;
  // One iteration: shift right, then pull every digit >= 8 back down by 3
  always_comb begin
    shifted = {bcd_reg, bin_reg} >> 1;
    bcd_adj = shifted[BCD_W+BIN_W-1 -: BCD_W];
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad = bad | (bcd_reg[4*i +: 4] > 4'd9);
      if (bcd_adj[4*i +: 4] >= 4'd8) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] - 4'd3;
    end
  end
  assign last = cnt == CNT_W'(BIN_W - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.start ? CHECK : IDLE;
      CHECK:   nxt = bad ? FINISH : SHIFT;
      SHIFT:   nxt = last ? FINISH : SHIFT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bcd_reg     <= '0;
      bin_reg     <= '0;
      cnt         <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.bin_out <= '0;
      bus.err     <= 1'b0;
    end else begin
      bus.busy <= nxt == CHECK || nxt == SHIFT;
      bus.done <= nxt == FINISH;
      if (state == IDLE && bus.start) begin
        bcd_reg <= bus.bcd_in;
        bin_reg <= '0;
        cnt     <= '0;
      end
      if (state == SHIFT) begin
        {bcd_reg, bin_reg} <= {bcd_adj, shifted[BIN_W-1:0]};
        cnt <= cnt + 1'b1;
      end
      // Result is captured on the edge entering FINISH so it is valid alongside done
      if (nxt == FINISH) begin
        bus.bin_out <= state == SHIFT ? shifted[BIN_W-1:0] : '0;
        bus.err     <= state == CHECK;
      end
    end
endmodule
